// File: rtl/scan_pkg.sv
// rtl/scan_pkg.sv - scan FSM state type and default VGA 640x480 timing constants
package scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } scan_state_t;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_PIPE_LAT = 2;

endpackage

// File: rtl/scan_delay.sv
// rtl/scan_delay.sv - fixed-depth register delay line with a per-bit reset value
module scan_delay #(
  parameter int                DEPTH   = 2,
  parameter int                WIDTH   = 3,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign o_data = i_data;
    end else begin : g_pipe
      logic [WIDTH-1:0] r_stage [DEPTH];

      // shift the sideband one stage per clock; reset loads the idle pattern
      always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
          for (int i = 0; i < DEPTH; i++) r_stage[i] <= RST_VAL;
        end else begin
          r_stage[0] <= i_data;
          for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
        end
      end

      assign o_data = r_stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/tilemap_scan_ctrl.sv
// rtl/tilemap_scan_ctrl.sv - raster scan controller; optional SCAN_TEST_PATTERN_EN replaces renderer colour with a pattern
module tilemap_scan_ctrl
  import scan_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int PIPE_LAT = DEF_PIPE_LAT
) (
  input  logic       clk,
  input  logic       rst_l,
  input  logic       en,
  output logic [9:0] col,
  output logic [8:0] row,
  input  logic [3:0] red,
  input  logic [3:0] green,
  input  logic [3:0] blue,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b,
  output logic       hsync_l,
  output logic       vsync_l,
  output logic       frame_start
);

  localparam logic [9:0] H_LAST     = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST     = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS      = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);
  localparam logic [9:0] H_SYNC_ON  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_OFF = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_SYNC_ON  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_OFF = 10'(V_ACTIVE + V_FP + V_SYNC);

`ifdef SCAN_TEST_PATTERN_EN
  localparam int PIPE_W = 19;
`else
  localparam int PIPE_W = 3;
`endif
  // flags live in the low bits: {active, hsync_l, vsync_l}, idle = 0,1,1
  localparam logic [PIPE_W-1:0] PIPE_RST = PIPE_W'(3'b011);

  scan_state_t r_state;
  logic [9:0]  r_hcnt;
  logic [9:0]  r_vcnt;
  logic        r_frame_start;

  logic              w_run;
  logic              w_active;
  logic              w_hsync_l;
  logic              w_vsync_l;
  logic [PIPE_W-1:0] w_pipe_in;
  logic [PIPE_W-1:0] w_pipe_out;

  // scan FSM: IDLE waits for en, ARM launches a frame, RUN walks the raster
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_state       <= IDLE;
      r_hcnt        <= '0;
      r_vcnt        <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= 1'b0;
      case (r_state)
        IDLE: begin
          r_hcnt <= '0;
          r_vcnt <= '0;
          if (en) r_state <= ARM;
        end
        ARM: begin
          r_hcnt        <= '0;
          r_vcnt        <= '0;
          r_frame_start <= 1'b1;
          r_state       <= RUN;
        end
        RUN: begin
          if (r_hcnt == H_LAST) begin
            r_hcnt <= '0;
            if (r_vcnt == V_LAST) begin
              // en is only honoured at the frame boundary
              r_vcnt <= '0;
              if (en) r_frame_start <= 1'b1;
              else    r_state       <= IDLE;
            end else begin
              r_vcnt <= r_vcnt + 10'd1;
            end
          end else begin
            r_hcnt <= r_hcnt + 10'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_run       = (r_state == RUN);
  assign w_active    = w_run && (r_hcnt < H_VIS) && (r_vcnt < V_VIS);
  assign w_hsync_l   = !(w_run && (r_hcnt >= H_SYNC_ON) && (r_hcnt < H_SYNC_OFF));
  assign w_vsync_l   = !(w_run && (r_vcnt >= V_SYNC_ON) && (r_vcnt < V_SYNC_OFF));
  assign col         = w_active ? r_hcnt : 10'd0;
  assign row         = w_active ? r_vcnt[8:0] : 9'd0;
  assign frame_start = r_frame_start;

`ifdef SCAN_TEST_PATTERN_EN
  logic w_unused_rgb;
  assign w_unused_rgb = ^{red, green, blue};
  assign w_pipe_in    = {col[7:0], row[7:0], w_active, w_hsync_l, w_vsync_l};
`else
  assign w_pipe_in    = {w_active, w_hsync_l, w_vsync_l};
`endif

  scan_delay #(
    .DEPTH   (PIPE_LAT),
    .WIDTH   (PIPE_W),
    .RST_VAL (PIPE_RST)
  ) u_delay (
    .clk    (clk),
    .rst_l  (rst_l),
    .i_data (w_pipe_in),
    .o_data (w_pipe_out)
  );

  // output register: sync and colour leave together, colour blanked outside active
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      vga_r   <= '0;
      vga_g   <= '0;
      vga_b   <= '0;
      hsync_l <= 1'b1;
      vsync_l <= 1'b1;
    end else begin
      hsync_l <= w_pipe_out[1];
      vsync_l <= w_pipe_out[0];
      if (w_pipe_out[2]) begin
`ifdef SCAN_TEST_PATTERN_EN
        vga_r <= w_pipe_out[18:15];
        vga_g <= w_pipe_out[10:7];
        vga_b <= w_pipe_out[14:11] ^ w_pipe_out[6:3];
`else
        vga_r <= red;
        vga_g <= green;
        vga_b <= blue;
`endif
      end else begin
        vga_r <= '0;
        vga_g <= '0;
        vga_b <= '0;
      end
    end
  end

endmodule

// File: tb/tb_tilemap_scan_ctrl.sv
// tb/tb_tilemap_scan_ctrl.sv - directed self-checking bench for tilemap_scan_ctrl on a shrunken raster
module tb_tilemap_scan_ctrl;

  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 8,  VF = 1, VS = 2, VB = 2;
  localparam int LAT = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic       clk = 1'b0;
  logic       rst_l;
  logic       en;
  logic [9:0] col;
  logic [8:0] row;
  logic [3:0] red, green, blue;
  logic [3:0] vga_r, vga_g, vga_b;
  logic       hsync_l, vsync_l, frame_start;

  int total = 0;
  int bad   = 0;
  int hist [LAT+2];

  always #5 clk = ~clk;

  tilemap_scan_ctrl #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .PIPE_LAT (LAT)
  ) dut (
    .clk         (clk),
    .rst_l       (rst_l),
    .en          (en),
    .col         (col),
    .row         (row),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .hsync_l     (hsync_l),
    .vsync_l     (vsync_l),
    .frame_start (frame_start)
  );

  // two-clock renderer model
  logic [9:0] c1, c2;
  logic [8:0] r1, r2;
  always @(posedge clk) begin
    c1 <= col; c2 <= c1;
    r1 <= row; r2 <= r1;
  end
  assign red   = c2[3:0];
  assign green = r2[3:0];
  assign blue  = c2[3:0] ^ 4'hF;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // advance one clock; p is the raster position the bench expects issued (-1 = not running)
  task automatic step(input int p);
    int h, v, pd, hd, vd;
    bit act, actd;
    @(negedge clk);
    h   = (p >= 0) ? p % HT : 0;
    v   = (p >= 0) ? p / HT : 0;
    act = (p >= 0) && (h < HA) && (v < VA);
    chk($sformatf("col@%0d", p), int'(col), act ? h : 0);
    chk($sformatf("row@%0d", p), int'(row), act ? v : 0);
    chk($sformatf("fs@%0d", p), int'(frame_start), (p == 0) ? 1 : 0);
    for (int i = LAT + 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = p;
    pd   = hist[LAT+1];
    hd   = (pd >= 0) ? pd % HT : 0;
    vd   = (pd >= 0) ? pd / HT : 0;
    actd = (pd >= 0) && (hd < HA) && (vd < VA);
    chk($sformatf("hs@%0d", pd), int'(hsync_l),
        ((pd >= 0) && (hd >= HA + HF) && (hd < HA + HF + HS)) ? 0 : 1);
    chk($sformatf("vs@%0d", pd), int'(vsync_l),
        ((pd >= 0) && (vd >= VA + VF) && (vd < VA + VF + VS)) ? 0 : 1);
`ifdef SCAN_TEST_PATTERN_EN
    chk($sformatf("r@%0d", pd), int'(vga_r), actd ? (hd / 16) % 16 : 0);
    chk($sformatf("g@%0d", pd), int'(vga_g), actd ? (vd / 16) % 16 : 0);
    chk($sformatf("b@%0d", pd), int'(vga_b), actd ? ((hd % 16) ^ (vd % 16)) : 0);
`else
    chk($sformatf("r@%0d", pd), int'(vga_r), actd ? hd % 16 : 0);
    chk($sformatf("g@%0d", pd), int'(vga_g), actd ? vd % 16 : 0);
    chk($sformatf("b@%0d", pd), int'(vga_b), actd ? ((hd % 16) ^ 15) : 0);
`endif
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_col"}, int'(col), 0);
    chk({tag, "_row"}, int'(row), 0);
    chk({tag, "_r"},   int'(vga_r), 0);
    chk({tag, "_g"},   int'(vga_g), 0);
    chk({tag, "_b"},   int'(vga_b), 0);
    chk({tag, "_hs"},  int'(hsync_l), 1);
    chk({tag, "_vs"},  int'(vsync_l), 1);
    chk({tag, "_fs"},  int'(frame_start), 0);
  endtask

  initial begin
    for (int i = 0; i < LAT + 2; i++) hist[i] = -1;
    rst_l = 1'b0;
    en    = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    rst_l = 1'b1;
    step(-1);
    step(-1);

    // start: one IDLE->ARM clock, then frame_start with position 0
    en = 1'b1;
    step(-1);
    for (int k = 0; k < 2 * FT; k++) begin
      if (k == FT + 3 * HT) en = 1'b0;
      step(k % FT);
    end
    // en low at the frame end: back to IDLE, delay line drains
    repeat (6) step(-1);

    // re-enable, then reset at row 3, col 5
    en = 1'b1;
    step(-1);
    for (int k = 0; k <= 3 * HT + 5; k++) step(k);
    chk("pre_rst_col", int'(col), 5);
    chk("pre_rst_row", int'(row), 3);
    rst_l = 1'b0;
    #1;
    chk_reset_vals("async");
    @(negedge clk);
    chk_reset_vals("hold");
    rst_l = 1'b1;
    for (int i = 0; i < LAT + 2; i++) hist[i] = -1;
    step(-1);
    for (int k = 0; k < 2 * HT; k++) step(k);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tilemap_scan_ctrl.md
TILEMAP_SCAN_CTRL -- requirements
Module: tilemap_scan_ctrl

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 640, meaning visible pixels per line.
REQ-002 The block SHALL have parameters H_FP/H_SYNC/H_BP, defaults 16/96/48, meaning horizontal front porch, sync and back porch widths in clocks.
REQ-003 The block SHALL have parameter V_ACTIVE, default 480, meaning visible lines per frame.
REQ-004 The block SHALL have parameters V_FP/V_SYNC/V_BP, defaults 10/2/33, meaning vertical front porch, sync and back porch widths in lines.
REQ-005 The block SHALL have parameter PIPE_LAT, default 2, range 0..7, meaning renderer latency in clocks from col/row to red/green/blue.
REQ-006 clk  input  1  pixel clock; all state updates on its rising edge.
REQ-007 rst_l  input  1  asynchronous, active-low reset.
REQ-008 en  input  1  run request; sampled every clock.
REQ-009 col  output  10  horizontal scan position to renderer.
REQ-010 row  output  9  vertical scan position to renderer.
REQ-011 red, green, blue  input  4 each  renderer colour for the col/row issued PIPE_LAT clocks earlier.
REQ-012 vga_r, vga_g, vga_b  output  4 each  display colour.
REQ-013 hsync_l, vsync_l  output  1 each  active-low syncs.
REQ-014 frame_start  output  1  one-clock pulse when col=0, row=0 is issued.

Function
REQ-015 The FSM SHALL have states IDLE, ARM, RUN.
REQ-016 IDLE: counters held at 0; en=1 SHALL move to ARM the next clock.
REQ-017 ARM: one clock; SHALL pulse frame_start and move to RUN with hcnt=vcnt=0.
REQ-018 RUN: hcnt SHALL increment every clock and wrap at H_TOTAL-1 (H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP=800); vcnt SHALL increment on hcnt wrap and wrap at V_TOTAL-1 (525).
REQ-019 en deasserted in RUN SHALL take effect only at the last clock of the frame (hcnt=799, vcnt=524), then go to IDLE; en=1 there SHALL continue with frame_start pulsed at the wrap.
REQ-020 col/row SHALL equal hcnt/vcnt when both are in the active area, otherwise hold 0.
REQ-021 active=(hcnt<H_ACTIVE)&&(vcnt<V_ACTIVE); hsync_l=0 iff H_ACTIVE+H_FP<=hcnt<H_ACTIVE+H_FP+H_SYNC; vsync_l=0 iff V_ACTIVE+V_FP<=vcnt<V_ACTIVE+V_FP+V_SYNC.
REQ-022 active, hsync_l and vsync_l SHALL pass through a PIPE_LAT-stage delay line plus one output register, so they align with red/green/blue at the outputs.
REQ-023 vga_r/g/b SHALL be the registered renderer colour when the delayed active=1, else 0.
REQ-024 Output latency from col/row to vga_* SHALL be PIPE_LAT+1 clocks; PIPE_LAT=0 SHALL be legal.
REQ-025 Counter arithmetic SHALL be unsigned, with hcnt 10 bits and vcnt 10 bits; row SHALL be vcnt[8:0] taken only inside the active area.
REQ-026 In IDLE, hsync_l and vsync_l SHALL be 1 and vga_* 0 once the delay line drains.

Reset
REQ-027 rst_l=0 SHALL asynchronously force IDLE, hcnt=vcnt=0, col=0, row=0, vga_*=0, hsync_l=1, vsync_l=1, frame_start=0, and all delay-line stages to active=0, hsync=1, vsync=1.
REQ-028 Reset asserted mid-frame SHALL abort the frame; after release, a new frame SHALL start at col=0, row=0 through ARM.

Configuration
REQ-029 With SCAN_TEST_PATTERN_EN defined, vga_r/g/b in the active area SHALL be {col[7:4]}, {row[7:4]}, {col[3:0]^row[3:0]} of the aligned position, and red/green/blue SHALL be ignored.
REQ-030 Without SCAN_TEST_PATTERN_EN, the pattern logic SHALL be absent and REQ-023 SHALL apply.

Structure
REQ-031 Package scan_pkg SHALL hold the scan-state enum (IDLE, ARM, RUN) and default timing constants.
REQ-032 The delay line SHALL be one sub-module, scan_delay, parameterized by depth and width.

Verification
REQ-033 Reset, then en=1: frame_start pulses 2 clocks after en, col counts 0..639, then holds 0 for 160 clocks; row=1 at the start of the next line.
REQ-034 hsync_l=0 for exactly 96 clocks starting at hcnt=656 (+PIPE_LAT+1); vsync_l=0 for 2 lines starting at vcnt=490.
REQ-035 Drive red=col[3:0] with a 2-clock renderer model: vga_r equals red for each pixel; vga_r=0 outside the active area.
REQ-036 Drop en at row=100: scanning continues to hcnt=799, vcnt=524, then IDLE with counters at 0; reassert en: frame_start follows after ARM.
REQ-037 Assert rst_l=0 at row=3, col=5: outputs are at reset values immediately; after release with en=1, the scan restarts at col=0, row=0.
REQ-038 With SCAN_TEST_PATTERN_EN, at col=0x12, row=0x34, the output is vga_r=1, vga_g=3, vga_b=6.
